// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_BIT_INTERVAL = 868;  // 115200 baud at 100 MHz

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous FIFO; pointers carry one extra MSB to tell full from empty.
module uart_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                   (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_data  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

  // Full is judged on the pre-edge pointers, so a pop never frees room for a same-cycle push.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO front end, FSM, bit timer and registered line output.
// Define UART_TX_PARITY_EN to append an even-parity bit after data bit 7.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int BUF_ADDR_WIDTH = 10,
  parameter int BIT_INTERVAL   = UART_BIT_INTERVAL
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [7:0]              i_in_data,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  output logic                    o_uart_tx,
  output logic                    o_busy,
  output logic [BUF_ADDR_WIDTH:0] o_fifo_count
);

  localparam int TW = $clog2(BIT_INTERVAL);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_INTERVAL - 1);
  localparam logic [2:0]    LAST_BIT   = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            r_state;
  logic [TW-1:0]             r_timer;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_tx;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [7:0]                w_fifo_head;
  logic                      w_timer_done;
  logic                      w_pop;

  uart_fifo #(
    .DATA_WIDTH (UART_DATA_BITS),
    .ADDR_WIDTH (BUF_ADDR_WIDTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_in_valid),
    .i_data  (i_in_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (o_fifo_count)
  );

  assign w_timer_done = (r_timer == TIMER_LAST);
  assign w_pop = !w_fifo_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_timer_done));

  assign o_in_ready = !w_fifo_full;
  assign o_uart_tx  = r_tx;
  assign o_busy     = (r_state != IDLE) || !w_fifo_empty;

  // The line register follows the state one cycle late, so every bit still spans BIT_INTERVAL cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_timer <= (w_timer_done || (r_state == IDLE)) ? '0 : r_timer + 1'b1;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_fifo_head;
            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= even_parity(w_fifo_head);
`endif
            r_state   <= START;
          end
        end
        START: begin
          r_tx <= 1'b0;
          if (w_timer_done) r_state <= DATA;
        end
        DATA: begin
          r_tx <= r_shift[0];
          if (w_timer_done) begin
            r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          r_tx <= r_parity;
          if (w_timer_done) r_state <= STOP;
        end
`endif
        STOP: begin
          r_tx <= 1'b1;
          if (w_timer_done) begin
            if (w_pop) begin
              r_shift   <= w_fifo_head;
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_parity  <= even_parity(w_fifo_head);
`endif
              r_state   <= START;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised bench for uart_tx_buffered against a frame-schedule reference model.
module tb_uart_tx_buffered;

  localparam int AW    = 2;
  localparam int BI    = 8;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BI;
  localparam int MAXF  = 64;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic [7:0]    i_in_data = 8'h00;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic          o_uart_tx;
  logic          o_busy;
  logic [AW:0]   o_fifo_count;

  uart_tx_buffered #(
    .BUF_ADDR_WIDTH (AW),
    .BIT_INTERVAL   (BI)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_in_data    (i_in_data),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .o_uart_tx    (o_uart_tx),
    .o_busy       (o_busy),
    .o_fifo_count (o_fifo_count)
  );

  always #5 i_clk = ~i_clk;

  // Model: each accepted byte has a push edge and a pop edge; its frame starts the edge after the pop.
  int         t = 0;
  int         nf = 0;
  int         push_e [MAXF];
  int         pop_e  [MAXF];
  logic [7:0] dat    [MAXF];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic int model_count(input int tt);
    int c = 0;
    for (int i = 0; i < nf; i++) begin
      if (push_e[i] <= tt) c++;
      if (pop_e[i] <= tt) c--;
    end
    return c;
  endfunction

  function automatic logic model_line(input int tt);
    for (int i = 0; i < nf; i++) begin
      int s = pop_e[i] + 1;
      if (tt >= s && tt < s + FRAME) begin
        int k = (tt - s) / BI;
        if (k == 0) return 1'b0;
        if (k <= 8) return dat[i][k-1];
        if (NBITS == 11 && k == 9) return ^dat[i];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic model_busy(input int tt);
    if (model_count(tt) > 0) return 1'b1;
    for (int i = 0; i < nf; i++)
      if (tt >= pop_e[i] && tt < pop_e[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("uart_tx", 32'(o_uart_tx), 32'(model_line(t)));
    chk("fifo_count", 32'(o_fifo_count), 32'(model_count(t)));
    chk("in_ready", 32'(o_in_ready), 32'(model_count(t) < DEPTH));
    chk("busy", 32'(o_busy), 32'(model_busy(t)));
  endtask

  task automatic step(input logic v, input logic [7:0] d, output logic acc);
    i_in_valid = v;
    i_in_data  = d;
    @(posedge i_clk);
    t++;
    acc = 1'b0;
    if (v && model_count(t - 1) < DEPTH && nf < MAXF) begin
      int e;
      e = t + 1;
      if (nf > 0 && pop_e[nf-1] + FRAME > e) e = pop_e[nf-1] + FRAME;
      push_e[nf] = t;
      pop_e[nf]  = e;
      dat[nf]    = d;
      nf++;
      acc = 1'b1;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), a);
  endtask

  task automatic send(input logic [7:0] d);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 300 && !a; i++) step(1'b1, d, a);
    chk("send_accepted", 32'(a), 32'(1));
    i_in_valid = 1'b0;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 3000 && model_busy(t); i++) step(1'b0, 8'h00, a);
    chk("drained_busy", 32'(o_busy), 32'(0));
  endtask

  task automatic do_reset();
    i_reset    = 1'b1;
    i_in_valid = 1'b0;
    @(posedge i_clk);
    t++;
    nf = 0;
    #1;
    check_all();
    i_reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0d observed=hang expected=finish", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int target;
    do_reset();
    idle(3);

    send(8'h55);
    idle(FRAME + 10);

    send(8'h00);
    send(8'hFF);
    drain();

    // Six bytes in a row: fills the depth-4 FIFO and holds valid across the pop edge.
    for (int i = 0; i < 6; i++) send(8'($urandom));
    drain();

    send(8'h07);
    drain();

    for (int i = 0; i < 15; i++) begin
      send(8'($urandom));
      idle(($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 120)) : int'($urandom_range(0, 6)));
    end
    drain();

    // Reset during data bit 3 of the first frame with two bytes queued behind it.
    do_reset();
    send(8'($urandom));
    send(8'($urandom));
    send(8'($urandom));
    target = pop_e[0] + 1 + 4 * BI + 3;
    for (int i = 0; i < 500 && t < target; i++) idle(1);
    chk("reset_point_reached", 32'(t), 32'(target));
    do_reset();
    idle(FRAME + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
